// File: rtl/constants_pkg.sv
// Shared memory-system constants plus the state/owner types used by the memory port arbiter.
package constants_pkg;

  localparam int MEMORY_ADDRESS_BITS = 8;
  localparam int MEMORY_DATA_BITS    = 8;

  typedef enum logic [1:0] {ARB_IDLE, ARB_ISSUE, ARB_WAIT, ARB_CAPTURE} arb_state_t;
  typedef enum logic {OWNER_FETCH, OWNER_DATA} arb_owner_t;

  // Saturating increment for the optional statistics counters.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick between fetch and data; last_owner advances only when update_en is set.
module rr_arbiter2
  import constants_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       req_fetch,
  input  logic       req_data,
  input  logic       update_en,
  output logic       gnt_valid,
  output arb_owner_t gnt_owner
);

  arb_owner_t last_owner;

  always_comb begin
    gnt_valid = req_fetch | req_data;
    gnt_owner = OWNER_FETCH;
    if (req_fetch && req_data) begin
      gnt_owner = (last_owner == OWNER_FETCH) ? OWNER_DATA : OWNER_FETCH;
    end else if (req_data) begin
      gnt_owner = OWNER_DATA;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_owner <= OWNER_FETCH;
    end else if (update_en && gnt_valid) begin
      last_owner <= gnt_owner;
    end
  end

endmodule

// File: rtl/memory_port_arbiter.sv
// Shares the mux read/write ports between fetch and load/store; one read in flight at a time.
// Optional statistics counters are built when MEMORY_PORT_ARBITER_STATS_EN is defined.
module memory_port_arbiter
  import constants_pkg::*;
#(
  parameter int RD_LATENCY = 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           fetch_req,
  input  logic [MEMORY_ADDRESS_BITS-1:0] fetch_addr,
  output logic                           fetch_gnt,
  output logic [MEMORY_DATA_BITS-1:0]    fetch_rdata,
  output logic                           fetch_rvalid,
  input  logic                           data_req,
  input  logic                           data_we,
  input  logic [MEMORY_ADDRESS_BITS-1:0] data_addr,
  input  logic [MEMORY_DATA_BITS-1:0]    data_wdata,
  output logic                           data_gnt,
  output logic [MEMORY_DATA_BITS-1:0]    data_rdata,
  output logic                           data_rvalid,
  output logic                           rd_mem_en,
  output logic [MEMORY_ADDRESS_BITS-1:0] rd_mem_addr,
  input  logic [MEMORY_DATA_BITS-1:0]    rd_mem_data,
  output logic                           wr_mem_en,
  output logic [MEMORY_ADDRESS_BITS-1:0] wr_mem_addr,
  output logic [MEMORY_DATA_BITS-1:0]    wr_mem_data,
`ifdef MEMORY_PORT_ARBITER_STATS_EN
  output logic [15:0]                    stat_fetch_grants,
  output logic [15:0]                    stat_data_grants,
  output logic [15:0]                    stat_conflict_cycles,
`endif
  output arb_state_t                     dbg_state
);

  if (RD_LATENCY < 1) begin : g_bad_latency
    $error("memory_port_arbiter: RD_LATENCY must be >= 1");
  end

  localparam int CNT_W = (RD_LATENCY > 2) ? $clog2(RD_LATENCY - 1) : 1;
  localparam logic [CNT_W-1:0] WAIT_LOAD = (RD_LATENCY > 2) ? CNT_W'(RD_LATENCY - 2) : '0;

  arb_state_t       state, state_next;
  arb_owner_t       rd_owner, win_owner;
  logic             win_valid;
  logic [CNT_W-1:0] wait_cnt;
  logic             arb_slot, rd_go, fetch_go, data_rd_go, wr_req, wr_hazard, wr_go;

  // Handshake: a requester holds req and its qualifiers stable until it sees gnt high; the edge
  // that closes the gnt cycle already samples the requester's next request (or idle).
  assign arb_slot   = (state == ARB_IDLE) || (state == ARB_CAPTURE);
  assign rd_go      = arb_slot && win_valid;
  assign fetch_go   = rd_go && (win_owner == OWNER_FETCH);
  assign data_rd_go = rd_go && (win_owner == OWNER_DATA);
  assign wr_req     = data_req && data_we;
  // A store to the address fetch is reading this edge waits one slot so the read sees old data.
  assign wr_hazard  = wr_req && fetch_go && (data_addr == fetch_addr);
  assign wr_go      = arb_slot && wr_req && !wr_hazard;
  assign dbg_state  = state;

  rr_arbiter2 u_rr (
    .clk       (clk),
    .reset     (reset),
    .req_fetch (fetch_req),
    .req_data  (data_req && !data_we),
    .update_en (arb_slot),
    .gnt_valid (win_valid),
    .gnt_owner (win_owner)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ARB_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ARB_IDLE:    if (rd_go) state_next = ARB_ISSUE;
      ARB_ISSUE:   state_next = (RD_LATENCY > 1) ? ARB_WAIT : ARB_CAPTURE;
      ARB_WAIT:    if (wait_cnt == '0) state_next = ARB_CAPTURE;
      ARB_CAPTURE: state_next = rd_go ? ARB_ISSUE : ARB_IDLE;
      default:     state_next = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_owner     <= OWNER_FETCH;
      wait_cnt     <= '0;
      fetch_gnt    <= 1'b0;
      data_gnt     <= 1'b0;
      rd_mem_en    <= 1'b0;
      rd_mem_addr  <= '0;
      wr_mem_en    <= 1'b0;
      wr_mem_addr  <= '0;
      wr_mem_data  <= '0;
      fetch_rvalid <= 1'b0;
      fetch_rdata  <= '0;
      data_rvalid  <= 1'b0;
      data_rdata   <= '0;
    end else begin
      fetch_gnt    <= fetch_go;
      data_gnt     <= data_rd_go || wr_go;
      rd_mem_en    <= rd_go;
      wr_mem_en    <= wr_go;
      fetch_rvalid <= (state == ARB_CAPTURE) && (rd_owner == OWNER_FETCH);
      data_rvalid  <= (state == ARB_CAPTURE) && (rd_owner == OWNER_DATA);
      if (state == ARB_CAPTURE) begin
        if (rd_owner == OWNER_FETCH) fetch_rdata <= rd_mem_data;
        else                         data_rdata  <= rd_mem_data;
      end
      if (rd_go) begin
        rd_mem_addr <= (win_owner == OWNER_FETCH) ? fetch_addr : data_addr;
        rd_owner    <= win_owner;
      end
      if (wr_go) begin
        wr_mem_addr <= data_addr;
        wr_mem_data <= data_wdata;
      end
      if (state == ARB_ISSUE)     wait_cnt <= WAIT_LOAD;
      else if (state == ARB_WAIT) wait_cnt <= wait_cnt - 1'b1;
    end
  end

`ifdef MEMORY_PORT_ARBITER_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_fetch_grants    <= '0;
      stat_data_grants     <= '0;
      stat_conflict_cycles <= '0;
    end else begin
      if (fetch_go) stat_fetch_grants <= sat_inc16(stat_fetch_grants);
      if (data_rd_go || wr_go) stat_data_grants <= sat_inc16(stat_data_grants);
      if (arb_slot && ((fetch_req && data_req && !data_we) || wr_hazard))
        stat_conflict_cycles <= sat_inc16(stat_conflict_cycles);
    end
  end
`endif

endmodule

// File: tb/tb_memory_port_arbiter.sv
// Directed bench for memory_port_arbiter: table of per-cycle vectors on an RD_LATENCY=1 instance,
// plus hand sequences on an RD_LATENCY=3 instance (and the counters when MEMORY_PORT_ARBITER_STATS_EN).
module tb_memory_port_arbiter;
  import constants_pkg::*;

  localparam int AW = MEMORY_ADDRESS_BITS;
  localparam int DW = MEMORY_DATA_BITS;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset, reset_l3;
  always #5 clk = ~clk;

  // ---------------- shared requester inputs ----------------
  logic          fetch_req, data_req, data_we;
  logic [AW-1:0] fetch_addr, data_addr;
  logic [DW-1:0] data_wdata;

  // ---------------- RD_LATENCY=1 instance ----------------
  logic          fetch_gnt, fetch_rvalid, data_gnt, data_rvalid, rd_mem_en, wr_mem_en;
  logic [DW-1:0] fetch_rdata, data_rdata, rd_mem_data, wr_mem_data;
  logic [AW-1:0] rd_mem_addr, wr_mem_addr;
  arb_state_t    dbg_state;
`ifdef MEMORY_PORT_ARBITER_STATS_EN
  logic [15:0]   stat_fetch_grants, stat_data_grants, stat_conflict_cycles;
`endif

  memory_port_arbiter #(.RD_LATENCY(1)) u1 (
    .clk(clk), .reset(reset),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_gnt(fetch_gnt),
    .fetch_rdata(fetch_rdata), .fetch_rvalid(fetch_rvalid),
    .data_req(data_req), .data_we(data_we), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_gnt(data_gnt), .data_rdata(data_rdata), .data_rvalid(data_rvalid),
    .rd_mem_en(rd_mem_en), .rd_mem_addr(rd_mem_addr), .rd_mem_data(rd_mem_data),
    .wr_mem_en(wr_mem_en), .wr_mem_addr(wr_mem_addr), .wr_mem_data(wr_mem_data),
`ifdef MEMORY_PORT_ARBITER_STATS_EN
    .stat_fetch_grants(stat_fetch_grants), .stat_data_grants(stat_data_grants),
    .stat_conflict_cycles(stat_conflict_cycles),
`endif
    .dbg_state(dbg_state)
  );

  // ---------------- RD_LATENCY=3 instance ----------------
  logic          l3_fetch_gnt, l3_fetch_rvalid, l3_data_gnt, l3_data_rvalid, l3_rd_mem_en, l3_wr_mem_en;
  logic [DW-1:0] l3_fetch_rdata, l3_data_rdata, l3_rd_mem_data, l3_wr_mem_data;
  logic [AW-1:0] l3_rd_mem_addr, l3_wr_mem_addr;
  arb_state_t    l3_dbg_state;
`ifdef MEMORY_PORT_ARBITER_STATS_EN
  logic [15:0]   l3_stat_fetch_grants, l3_stat_data_grants, l3_stat_conflict_cycles;
`endif

  memory_port_arbiter #(.RD_LATENCY(3)) u3 (
    .clk(clk), .reset(reset_l3),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_gnt(l3_fetch_gnt),
    .fetch_rdata(l3_fetch_rdata), .fetch_rvalid(l3_fetch_rvalid),
    .data_req(data_req), .data_we(data_we), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_gnt(l3_data_gnt), .data_rdata(l3_data_rdata), .data_rvalid(l3_data_rvalid),
    .rd_mem_en(l3_rd_mem_en), .rd_mem_addr(l3_rd_mem_addr), .rd_mem_data(l3_rd_mem_data),
    .wr_mem_en(l3_wr_mem_en), .wr_mem_addr(l3_wr_mem_addr), .wr_mem_data(l3_wr_mem_data),
`ifdef MEMORY_PORT_ARBITER_STATS_EN
    .stat_fetch_grants(l3_stat_fetch_grants), .stat_data_grants(l3_stat_data_grants),
    .stat_conflict_cycles(l3_stat_conflict_cycles),
`endif
    .dbg_state(l3_dbg_state)
  );

  // ---------------- memory model: mem[a] = ~a except mem[0x10] = 0xA5 ----------------
  logic [DW-1:0] mem [256];
  logic [DW-1:0] l3_p1, l3_p2;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) mem[i] <= (i == 16) ? 8'hA5 : ~8'(i);
    end else if (wr_mem_en) begin
      mem[wr_mem_addr] <= wr_mem_data;
    end
  end

  always @(posedge clk or posedge reset) begin
    if (reset)          rd_mem_data <= '0;
    else if (rd_mem_en) rd_mem_data <= mem[rd_mem_addr];
  end

  always @(posedge clk or posedge reset_l3) begin
    if (reset_l3) begin
      l3_p1 <= '0; l3_p2 <= '0; l3_rd_mem_data <= '0;
    end else begin
      l3_p1 <= l3_rd_mem_en ? mem[l3_rd_mem_addr] : '0;
      l3_p2 <= l3_p1;
      l3_rd_mem_data <= l3_p2;
    end
  end

  // ---------------- scoreboard ----------------
  int n_vec, n_err;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic fr; logic [AW-1:0] fa; logic dr; logic dw; logic [AW-1:0] da; logic [DW-1:0] dd;
    logic fg; logic dg; logic ren; logic [AW-1:0] raddr;
    logic wen; logic [AW-1:0] waddr; logic [DW-1:0] wdata;
    logic frv; logic [DW-1:0] frd; logic drv; logic [DW-1:0] drd;
  } vec_t;

  vec_t vecs[$];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] lat;
    logic       got, seen;
    n_vec = 0; n_err = 0;
    fetch_req = 0; fetch_addr = '0; data_req = 0; data_we = 0; data_addr = '0; data_wdata = '0;
    reset = 1; reset_l3 = 1;

    // inputs: fr fa dr dw da dd | expected: fg dg ren raddr wen waddr wdata frv frd drv drd
    // fetch 0x10, memory returns 0xA5
    vecs.push_back(vec_t'{1, 8'h10, 0, 0, 8'h00, 8'h00, 1, 0, 1, 8'h10, 0, 8'h00, 8'h00, 0, 8'h00, 0, 8'h00});
    vecs.push_back(vec_t'{0, 8'h10, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h10, 0, 8'h00, 8'h00, 0, 8'h00, 0, 8'h00});
    vecs.push_back(vec_t'{0, 8'h10, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h10, 0, 8'h00, 8'h00, 1, 8'hA5, 0, 8'h00});
    vecs.push_back(vec_t'{0, 8'h10, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h10, 0, 8'h00, 8'h00, 0, 8'hA5, 0, 8'h00});
    // fetch 0x20 vs load 0x30: data first, then alternation over four reads
    vecs.push_back(vec_t'{1, 8'h20, 1, 0, 8'h30, 8'h00, 0, 1, 1, 8'h30, 0, 8'h00, 8'h00, 0, 8'hA5, 0, 8'h00});
    vecs.push_back(vec_t'{1, 8'h20, 0, 0, 8'h30, 8'h00, 0, 0, 0, 8'h30, 0, 8'h00, 8'h00, 0, 8'hA5, 0, 8'h00});
    vecs.push_back(vec_t'{1, 8'h20, 0, 0, 8'h30, 8'h00, 1, 0, 1, 8'h20, 0, 8'h00, 8'h00, 0, 8'hA5, 1, 8'hCF});
    vecs.push_back(vec_t'{0, 8'h20, 1, 0, 8'h31, 8'h00, 0, 0, 0, 8'h20, 0, 8'h00, 8'h00, 0, 8'hA5, 0, 8'hCF});
    vecs.push_back(vec_t'{0, 8'h20, 1, 0, 8'h31, 8'h00, 0, 1, 1, 8'h31, 0, 8'h00, 8'h00, 1, 8'hDF, 0, 8'hCF});
    vecs.push_back(vec_t'{1, 8'h21, 0, 0, 8'h31, 8'h00, 0, 0, 0, 8'h31, 0, 8'h00, 8'h00, 0, 8'hDF, 0, 8'hCF});
    vecs.push_back(vec_t'{1, 8'h21, 0, 0, 8'h31, 8'h00, 1, 0, 1, 8'h21, 0, 8'h00, 8'h00, 0, 8'hDF, 1, 8'hCE});
    vecs.push_back(vec_t'{0, 8'h21, 0, 0, 8'h31, 8'h00, 0, 0, 0, 8'h21, 0, 8'h00, 8'h00, 0, 8'hDF, 0, 8'hCE});
    vecs.push_back(vec_t'{0, 8'h21, 0, 0, 8'h31, 8'h00, 0, 0, 0, 8'h21, 0, 8'h00, 8'h00, 1, 8'hDE, 0, 8'hCE});
    // fetch 0x40 with store 0x50/0x77 on the same edge
    vecs.push_back(vec_t'{1, 8'h40, 1, 1, 8'h50, 8'h77, 1, 1, 1, 8'h40, 1, 8'h50, 8'h77, 0, 8'hDE, 0, 8'hCE});
    vecs.push_back(vec_t'{0, 8'h40, 0, 0, 8'h50, 8'h77, 0, 0, 0, 8'h40, 0, 8'h50, 8'h77, 0, 8'hDE, 0, 8'hCE});
    vecs.push_back(vec_t'{0, 8'h40, 0, 0, 8'h50, 8'h77, 0, 0, 0, 8'h40, 0, 8'h50, 8'h77, 1, 8'hBF, 0, 8'hCE});
    // fetch 0x60 with store 0x60/0x66: store waits for the CAPTURE edge, read sees old 0x9F
    vecs.push_back(vec_t'{1, 8'h60, 1, 1, 8'h60, 8'h66, 1, 0, 1, 8'h60, 0, 8'h50, 8'h77, 0, 8'hBF, 0, 8'hCE});
    vecs.push_back(vec_t'{0, 8'h60, 1, 1, 8'h60, 8'h66, 0, 0, 0, 8'h60, 0, 8'h50, 8'h77, 0, 8'hBF, 0, 8'hCE});
    vecs.push_back(vec_t'{0, 8'h60, 1, 1, 8'h60, 8'h66, 0, 1, 0, 8'h60, 1, 8'h60, 8'h66, 1, 8'h9F, 0, 8'hCE});
    vecs.push_back(vec_t'{0, 8'h60, 0, 0, 8'h60, 8'h66, 0, 0, 0, 8'h60, 0, 8'h60, 8'h66, 0, 8'h9F, 0, 8'hCE});
    vecs.push_back(vec_t'{1, 8'h60, 0, 0, 8'h60, 8'h66, 1, 0, 1, 8'h60, 0, 8'h60, 8'h66, 0, 8'h9F, 0, 8'hCE});
    vecs.push_back(vec_t'{0, 8'h60, 0, 0, 8'h60, 8'h66, 0, 0, 0, 8'h60, 0, 8'h60, 8'h66, 0, 8'h9F, 0, 8'hCE});
    vecs.push_back(vec_t'{0, 8'h60, 0, 0, 8'h60, 8'h66, 0, 0, 0, 8'h60, 0, 8'h60, 8'h66, 1, 8'h66, 0, 8'hCE});
    // load 0x32 alone, then fetch 0x22 vs load 0x33 with last_owner = data: fetch first
    vecs.push_back(vec_t'{0, 8'h60, 1, 0, 8'h32, 8'h00, 0, 1, 1, 8'h32, 0, 8'h60, 8'h66, 0, 8'h66, 0, 8'hCE});
    vecs.push_back(vec_t'{0, 8'h60, 0, 0, 8'h32, 8'h00, 0, 0, 0, 8'h32, 0, 8'h60, 8'h66, 0, 8'h66, 0, 8'hCE});
    vecs.push_back(vec_t'{0, 8'h60, 0, 0, 8'h32, 8'h00, 0, 0, 0, 8'h32, 0, 8'h60, 8'h66, 0, 8'h66, 1, 8'hCD});
    vecs.push_back(vec_t'{1, 8'h22, 1, 0, 8'h33, 8'h00, 1, 0, 1, 8'h22, 0, 8'h60, 8'h66, 0, 8'h66, 0, 8'hCD});
    vecs.push_back(vec_t'{0, 8'h22, 1, 0, 8'h33, 8'h00, 0, 0, 0, 8'h22, 0, 8'h60, 8'h66, 0, 8'h66, 0, 8'hCD});
    vecs.push_back(vec_t'{0, 8'h22, 1, 0, 8'h33, 8'h00, 0, 1, 1, 8'h33, 0, 8'h60, 8'h66, 1, 8'hDD, 0, 8'hCD});
    vecs.push_back(vec_t'{0, 8'h22, 0, 0, 8'h33, 8'h00, 0, 0, 0, 8'h33, 0, 8'h60, 8'h66, 0, 8'hDD, 0, 8'hCD});
    vecs.push_back(vec_t'{0, 8'h22, 0, 0, 8'h33, 8'h00, 0, 0, 0, 8'h33, 0, 8'h60, 8'h66, 0, 8'hDD, 1, 8'hCC});

    repeat (3) @(posedge clk);
    @(negedge clk) reset = 0;
    check("reset_outputs", {fetch_gnt, fetch_rdata, fetch_rvalid, data_gnt, data_rdata, data_rvalid,
                            rd_mem_en, rd_mem_addr, wr_mem_en, wr_mem_addr, wr_mem_data, dbg_state}, '0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      fetch_req = vecs[i].fr; fetch_addr = vecs[i].fa;
      data_req = vecs[i].dr; data_we = vecs[i].dw; data_addr = vecs[i].da; data_wdata = vecs[i].dd;
      @(posedge clk); #1;
      check($sformatf("vec%0d", i),
            {fetch_gnt, data_gnt, rd_mem_en, rd_mem_addr, wr_mem_en, wr_mem_addr, wr_mem_data,
             fetch_rvalid, fetch_rdata, data_rvalid, data_rdata},
            {vecs[i].fg, vecs[i].dg, vecs[i].ren, vecs[i].raddr, vecs[i].wen, vecs[i].waddr,
             vecs[i].wdata, vecs[i].frv, vecs[i].frd, vecs[i].drv, vecs[i].drd});
    end

    // RD_LATENCY=3: load 0xFC, rvalid four cycles after the grant
    @(negedge clk);
    reset_l3 = 0; fetch_req = 0; data_req = 0; data_we = 0;
    @(negedge clk);
    check("l3_reset_outputs", {l3_fetch_gnt, l3_fetch_rdata, l3_fetch_rvalid, l3_data_gnt, l3_data_rdata,
                               l3_data_rvalid, l3_rd_mem_en, l3_rd_mem_addr, l3_wr_mem_en, l3_dbg_state}, '0);
    data_req = 1; data_addr = 8'hFC;
    @(posedge clk); #1;
    check("l3_grant", {l3_data_gnt, l3_rd_mem_en, l3_rd_mem_addr}, {1'b1, 1'b1, 8'hFC});
    @(negedge clk) data_req = 0;
    lat = '0; got = 0;
    for (int k = 1; k <= 10 && !got; k++) begin
      @(posedge clk); #1;
      if (l3_data_rvalid) begin
        got = 1;
        lat = 4'(k);
      end
    end
    check("l3_latency", {got, lat}, {1'b1, 4'd4});
    check("l3_rdata", l3_data_rdata, 8'h03);

    // reset while in WAIT drops the read
    @(negedge clk) data_req = 1;
    @(posedge clk);
    @(negedge clk) data_req = 0;
    @(posedge clk); #1;
    check("l3_in_wait", l3_dbg_state, ARB_WAIT);
    reset_l3 = 1; #1;
    check("l3_reset_in_wait", {l3_fetch_gnt, l3_fetch_rdata, l3_fetch_rvalid, l3_data_gnt, l3_data_rdata,
                               l3_data_rvalid, l3_rd_mem_en, l3_rd_mem_addr, l3_wr_mem_en, l3_dbg_state}, '0);
    @(negedge clk) reset_l3 = 0;
    seen = 0;
    repeat (8) begin
      @(posedge clk); #1;
      seen = seen | l3_data_rvalid | l3_fetch_rvalid;
    end
    check("l3_no_rvalid_after_reset", seen, 1'b0);

`ifdef MEMORY_PORT_ARBITER_STATS_EN
    // 3 fetch grants, 2 data grants (load + store), 1 conflicting edge
    @(negedge clk) reset = 1;
    @(negedge clk) reset = 0;
    check("stats_reset", {stat_fetch_grants, stat_data_grants, stat_conflict_cycles}, '0);
    @(negedge clk);
    fetch_req = 1; fetch_addr = 8'h10; data_req = 1; data_we = 0; data_addr = 8'h30;
    @(posedge clk);
    @(negedge clk) data_req = 0;
    repeat (2) @(posedge clk);
    @(negedge clk) fetch_req = 0;
    repeat (3) @(posedge clk);
    for (int n = 0; n < 2; n++) begin
      @(negedge clk) begin fetch_req = 1; fetch_addr = 8'h11; end
      @(posedge clk);
      @(negedge clk) fetch_req = 0;
      repeat (3) @(posedge clk);
    end
    @(negedge clk);
    data_req = 1; data_we = 1; data_addr = 8'h70; data_wdata = 8'h01;
    @(posedge clk);
    @(negedge clk) data_req = 0;
    @(posedge clk); #1;
    check("stats_counts", {stat_fetch_grants, stat_data_grants, stat_conflict_cycles},
          {16'd3, 16'd2, 16'd1});
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/memory_port_arbiter.md
Name: memory_port_arbiter

Overview:
- Shares the single read port and single write port of the memory/IO mux between two requesters: instruction fetch (read-only) and data load/store.
- Sits between the core's fetch and load/store units and the memory/IO mux.
- Owns all sequencing on the mux side: arbitration, read-latency tracking, read-data return and write issue.
- Only one read is in flight at a time. A data write may issue in the same cycle as a fetch read grant.

Parameters:
- RD_LATENCY, 1: cycles from the rd_mem_en cycle to valid rd_mem_data. Must be >= 1; illegal values are an elaboration error.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  reset; asynchronous, active-high.
- fetch_req  in  1  fetch read request. Held, with fetch_addr stable, until fetch_gnt.
- fetch_addr  in  MEMORY_ADDRESS_BITS  fetch address.
- fetch_gnt  out  1  one-cycle grant pulse.
- fetch_rdata  out  MEMORY_DATA_BITS  returned instruction byte.
- fetch_rvalid  out  1  one-cycle pulse; fetch_rdata is valid in this cycle.
- data_req  in  1  load/store request. Held, with all qualifiers stable, until data_gnt.
- data_we  in  1  1 = store, 0 = load.
- data_addr  in  MEMORY_ADDRESS_BITS  load/store address.
- data_wdata  in  MEMORY_DATA_BITS  store data.
- data_gnt  out  1  one-cycle grant pulse.
- data_rdata  out  MEMORY_DATA_BITS  load data.
- data_rvalid  out  1  one-cycle pulse; data_rdata is valid in this cycle.
- rd_mem_en  out  1  read enable to the mux.
- rd_mem_addr  out  MEMORY_ADDRESS_BITS  read address to the mux.
- rd_mem_data  in  MEMORY_DATA_BITS  read data from the mux.
- wr_mem_en  out  1  write enable to the mux.
- wr_mem_addr  out  MEMORY_ADDRESS_BITS  write address to the mux.
- wr_mem_data  out  MEMORY_DATA_BITS  write data to the mux.

Behaviour:
- Reset:
  - All outputs and data registers are 0.
  - State = IDLE; last_owner = OWNER_FETCH, so data wins the first conflict.
  - Reset mid-read drops the read: no rvalid is ever produced for it.
- All outputs are registered. Grants pulse in the same cycle as the matching rd_mem_en or wr_mem_en.
- FSM states:
  - IDLE: arbitration eligible.
  - ISSUE: rd_mem_en=1 for exactly one cycle, with rd_mem_addr and the owner latched. Next state is WAIT if RD_LATENCY>1, else CAPTURE.
  - WAIT: a counter loaded with RD_LATENCY-2 decrements each cycle. At 0 → CAPTURE.
  - CAPTURE: rd_mem_data is valid. At the end edge, the owner's rdata is registered and its rvalid pulses in the following cycle. This edge is also arbitration-eligible, like IDLE.
- Read arbitration (IDLE or CAPTURE, at the edge):
  - Candidates: fetch_req, and data_req with data_we=0.
  - Both present: the owner that is not last_owner wins; last_owner updates to the winner.
  - Winner → ISSUE. No candidate → IDLE.
  - Loser keeps its request held.
- Writes (data_req with data_we=1):
  - Eligible at any edge the FSM is IDLE or CAPTURE.
  - Issue: wr_mem_en=1, wr_mem_addr=data_addr, wr_mem_data=data_wdata and data_gnt=1, all for one cycle.
  - A write may issue in the same cycle that fetch is granted a read.
  - Hazard: if the write address equals the address of a fetch read being granted on the same edge, the write is held one arbitration slot (read-before-write order).
  - Writes never produce rvalid.
- Ownership: the data requester has at most one operation outstanding. It may reissue at the edge its data_rvalid or data_gnt (store) is asserted.
- Throughput: one read per RD_LATENCY+1 cycles under back-to-back requests.
- Fetch starvation bound: at most one data read between consecutive fetch grants.
- Address range: addresses 0xFC–0xFF are not special-cased here; IO decode is the mux's job.
- rdata outputs hold their last value until the next rvalid for that owner.

Optional Feature:
- Macro: MEMORY_PORT_ARBITER_STATS_EN.
- When defined, three extra outputs exist:
  - stat_fetch_grants, 16 bits.
  - stat_data_grants, 16 bits.
  - stat_conflict_cycles, 16 bits: counts edges where a read candidate lost arbitration or a write was held by the hazard rule.
- All three counters saturate at 0xFFFF and are cleared by reset.
- When not defined, the ports and logic are absent and behaviour is otherwise identical.

Decomposition:
- constants_pkg gains:
  - typedef enum arb_state_t {ARB_IDLE, ARB_ISSUE, ARB_WAIT, ARB_CAPTURE}.
  - typedef enum arb_owner_t {OWNER_FETCH, OWNER_DATA}.
- MEMORY_ADDRESS_BITS and MEMORY_DATA_BITS are reused from constants_pkg.
- One sub-module: rr_arbiter2, a 2-way round-robin pick with a last_owner register and an update enable.

Test Plan:
- Reset, then fetch_req with fetch_addr=0x10 → fetch_gnt and rd_mem_en pulse one cycle after the request edge, rd_mem_addr=0x10. With memory returning 0xA5 and RD_LATENCY=1, fetch_rvalid=1 with fetch_rdata=0xA5 two cycles after the grant.
- fetch_req (0x20) and data load (0x30) both held from reset → data granted first. Fetch is granted at the CAPTURE edge of the data read. Round-robin then alternates over 4 reads.
- Fetch read of 0x40 plus data store of 0x50/0x77 on the same edge → fetch_gnt, data_gnt, rd_mem_en and wr_mem_en all high in the same cycle.
- Fetch read of 0x60 plus store to 0x60 on the same edge → store delayed to the CAPTURE edge of the read. The read returns the old value.
- RD_LATENCY=3: load of 0xFC → rvalid exactly 4 cycles after data_gnt. Assert reset while in WAIT → all outputs 0, no rvalid afterwards.
- Stats build: 3 fetch grants, 2 data grants and 1 conflict → counters read 3, 2, 1.
